// File: rtl/vga_timing_pkg.sv
// Shared types, default 640x480@60 timing constants and frame-size helpers
// for the VGA raster timing generator.
package vga_timing_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } vga_lock_state_t;

    // 640x480 @ 60 Hz, 25.175 MHz pixel clock
    localparam int DEF_H_ACTIVE      = 640;
    localparam int DEF_H_FP          = 16;
    localparam int DEF_H_SYNC        = 96;
    localparam int DEF_H_BP          = 48;
    localparam int DEF_V_ACTIVE      = 480;
    localparam int DEF_V_FP          = 10;
    localparam int DEF_V_SYNC        = 2;
    localparam int DEF_V_BP          = 33;
    localparam int DEF_SETTLE_CYCLES = 1024;

    // Pixels per line including blanking
    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Lines per frame including blanking
    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the timing generator to the pixel/colour pipeline.
interface vga_timing_gen_if #(
    parameter int X_W = 10,
    parameter int Y_W = 10
);

    logic           hsync;
    logic           vsync;
    logic           de;
    logic [X_W-1:0] pixel_x;
    logic [Y_W-1:0] pixel_y;
    logic           line_start;
    logic           frame_start;
    logic           running;

    modport master (
        output hsync, vsync, de, pixel_x, pixel_y, line_start, frame_start, running
    );

    modport slave (
        input hsync, vsync, de, pixel_x, pixel_y, line_start, frame_start, running
    );

endinterface

// File: rtl/vga_timing_gen_lock_qualifier.sv
// Clock-lock qualifier: keeps the raster idle until the MMCM has reported
// lock for SETTLE_CYCLES consecutive cycles, and drops it on any lock loss.
module vga_lock_qualifier
    import vga_timing_pkg::*;
#(
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic pixel_clk,
    input  logic reset,
    input  logic locked,
    output logic run_en,
    output logic run_start
);

    // Counter only has to reach SETTLE_CYCLES-1; keep at least one bit.
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    vga_lock_state_t  state_q, state_d;
    logic [CNT_W-1:0] settle_cnt_q, settle_cnt_d;

    // State and settle counter registers; reset wins over every transition
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            state_q      <= WAIT_LOCK;
            settle_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
        end
    end

    // Next-state logic; run_start flags the edge that enters RUN
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = '0;
        run_start    = 1'b0;
        case (state_q)
            WAIT_LOCK: begin
                if (locked) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (!locked) begin
                    // Any glitch forces a full settle period again
                    state_d = WAIT_LOCK;
                end else if (settle_cnt_q == CNT_LAST) begin
                    state_d   = RUN;
                    run_start = 1'b1;
                end else begin
                    settle_cnt_d = settle_cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                if (!locked) begin
                    state_d = WAIT_LOCK;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
            end
        endcase
    end

    assign run_en = (state_q == RUN);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: horizontal/vertical counters gated by the
// lock qualifier, decoded into registered sync, data-enable, coordinates
// and line/frame strobes, all aligned one cycle after the counters.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE      = DEF_H_ACTIVE,
    parameter int   H_FP          = DEF_H_FP,
    parameter int   H_SYNC        = DEF_H_SYNC,
    parameter int   H_BP          = DEF_H_BP,
    parameter int   V_ACTIVE      = DEF_V_ACTIVE,
    parameter int   V_FP          = DEF_V_FP,
    parameter int   V_SYNC        = DEF_V_SYNC,
    parameter int   V_BP          = DEF_V_BP,
    parameter logic HSYNC_POL     = 1'b0,
    parameter logic VSYNC_POL     = 1'b0,
    parameter int   SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic             pixel_clk,
    input  logic             reset,
    input  logic             locked,
    vga_timing_gen_if.master vga
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int X_W     = $clog2(H_TOTAL);
    localparam int Y_W     = $clog2(V_TOTAL);
    // One spare bit so window edges equal to the total still fit
    localparam int XE_W    = X_W + 1;
    localparam int YE_W    = Y_W + 1;

    localparam logic [X_W-1:0]  H_LAST   = X_W'(H_TOTAL - 1);
    localparam logic [Y_W-1:0]  V_LAST   = Y_W'(V_TOTAL - 1);
    localparam logic [XE_W-1:0] H_ACT_E  = XE_W'(H_ACTIVE);
    localparam logic [XE_W-1:0] HS_BEG_E = XE_W'(H_ACTIVE + H_FP);
    localparam logic [XE_W-1:0] HS_END_E = XE_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YE_W-1:0] V_ACT_E  = YE_W'(V_ACTIVE);
    localparam logic [YE_W-1:0] VS_BEG_E = YE_W'(V_ACTIVE + V_FP);
    localparam logic [YE_W-1:0] VS_END_E = YE_W'(V_ACTIVE + V_FP + V_SYNC);

    logic run_en;
    logic run_start;

    logic [X_W-1:0] h_cnt_q, h_cnt_d;
    logic [Y_W-1:0] v_cnt_q, v_cnt_d;

    logic           hsync_q, hsync_d;
    logic           vsync_q, vsync_d;
    logic           de_q, de_d;
    logic [X_W-1:0] pixel_x_q, pixel_x_d;
    logic [Y_W-1:0] pixel_y_q, pixel_y_d;
    logic           line_start_q, line_start_d;
    logic           frame_start_q, frame_start_d;
    logic           running_q, running_d;

    vga_lock_qualifier #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_lock_qual (
        .pixel_clk (pixel_clk),
        .reset     (reset),
        .locked    (locked),
        .run_en    (run_en),
        .run_start (run_start)
    );

    // Raster counter next-state: parked at the origin outside RUN
    always_comb begin
        h_cnt_d = '0;
        v_cnt_d = '0;
        if (run_start) begin
            // First RUN cycle always starts at the frame origin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (run_en) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + Y_W'(1);
            end else begin
                h_cnt_d = h_cnt_q + X_W'(1);
                v_cnt_d = v_cnt_q;
            end
        end
    end

    // Raster counter registers
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Decode the current count into the next output word; idle when not running
    always_comb begin
        hsync_d       = ~HSYNC_POL;
        vsync_d       = ~VSYNC_POL;
        de_d          = 1'b0;
        pixel_x_d     = '0;
        pixel_y_d     = '0;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        running_d     = 1'b0;
        if (run_en) begin
            de_d          = ({1'b0, h_cnt_q} < H_ACT_E) && ({1'b0, v_cnt_q} < V_ACT_E);
            hsync_d       = (({1'b0, h_cnt_q} >= HS_BEG_E) && ({1'b0, h_cnt_q} < HS_END_E))
                            ? HSYNC_POL : ~HSYNC_POL;
            vsync_d       = (({1'b0, v_cnt_q} >= VS_BEG_E) && ({1'b0, v_cnt_q} < VS_END_E))
                            ? VSYNC_POL : ~VSYNC_POL;
            pixel_x_d     = h_cnt_q;
            pixel_y_d     = v_cnt_q;
            line_start_d  = (h_cnt_q == '0);
            frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
            running_d     = 1'b1;
        end
    end

    // Output registers: one cycle behind the counters, idle on reset
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            de_q          <= 1'b0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            running_q     <= 1'b0;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            running_q     <= running_d;
        end
    end

    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.de          = de_q;
    assign vga.pixel_x     = pixel_x_q;
    assign vga.pixel_y     = pixel_y_q;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;
    assign vga.running     = running_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen with a reduced raster (25x15) so that several
// full frames, lock loss, settle glitches and reset fit in a short run.
module tb_vga_timing_gen;

    localparam int H_ACTIVE = 16;
    localparam int H_FP     = 2;
    localparam int H_SYNC   = 4;
    localparam int H_BP     = 3;
    localparam int V_ACTIVE = 8;
    localparam int V_FP     = 2;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 3;
    localparam int SETTLE   = 16;
    localparam int HT       = 25;
    localparam int VT       = 15;
    localparam int X_W      = 5;
    localparam int Y_W      = 4;

    logic pixel_clk = 1'b0;
    logic reset;
    logic locked;

    always #5 pixel_clk = ~pixel_clk;

    vga_timing_gen_if #(.X_W(X_W), .Y_W(Y_W)) vga ();

    vga_timing_gen #(
        .H_ACTIVE      (H_ACTIVE),
        .H_FP          (H_FP),
        .H_SYNC        (H_SYNC),
        .H_BP          (H_BP),
        .V_ACTIVE      (V_ACTIVE),
        .V_FP          (V_FP),
        .V_SYNC        (V_SYNC),
        .V_BP          (V_BP),
        .HSYNC_POL     (1'b0),
        .VSYNC_POL     (1'b0),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .pixel_clk (pixel_clk),
        .reset     (reset),
        .locked    (locked),
        .vga       (vga)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [63:0] pack(input logic r, input logic fs, input logic ls,
                                         input logic de, input logic hs, input logic vs,
                                         input int x, input int y);
        return {38'd0, r, fs, ls, de, hs, vs, 10'(x), 10'(y)};
    endfunction

    function automatic logic [63:0] observed();
        return pack(vga.running, vga.frame_start, vga.line_start, vga.de,
                    vga.hsync, vga.vsync, int'(vga.pixel_x), int'(vga.pixel_y));
    endfunction

    // Model: s = consecutive edges with locked=1 and no reset. The raster is
    // running once s reaches SETTLE+1; the count is then s-SETTLE-1 cycles.
    function automatic logic [63:0] expected_out(input logic rst, input int s);
        int k, h, v;
        logic hs_act, vs_act;
        if (rst || s < SETTLE + 1) return pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0);
        k = s - SETTLE - 1;
        h = k % HT;
        v = (k / HT) % VT;
        hs_act = (h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC);
        vs_act = (v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC);
        return pack(1'b1, (h == 0) && (v == 0), h == 0,
                    (h < H_ACTIVE) && (v < V_ACTIVE), !hs_act, !vs_act, h, v);
    endfunction

    logic [63:0] exp_q[$];
    int streak = 0;

    // Scoreboard producer: expected output word for the edge just taken
    always @(posedge pixel_clk) begin
        exp_q.push_back(expected_out(reset, streak));
        streak <= (reset || !locked) ? 0 : streak + 1;
    end

    int since_fs = -1;
    int hs_run   = 0;
    int vs_run   = 0;
    logic vs_prev = 1'b1;

    // Scoreboard consumer plus frame-level invariants, sampled mid-cycle
    always @(negedge pixel_clk) begin
        logic [63:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val("raster", observed(), e);
        end
        if (!vga.running) begin
            since_fs = -1;
            hs_run   = 0;
            vs_run   = 0;
            vs_prev  = 1'b1;
        end else begin
            if (since_fs >= 0) since_fs++;
            if (vga.frame_start) begin
                check_val("ls_on_fs", 64'(vga.line_start), 64'd1);
                if (since_fs >= 0) check_val("frame_period", 64'(since_fs), 64'(HT * VT));
                since_fs = 0;
            end
            if (!vga.hsync) begin
                hs_run++;
            end else if (hs_run > 0) begin
                check_val("hsync_width", 64'(hs_run), 64'(H_SYNC));
                hs_run = 0;
            end
            if (!vga.vsync) begin
                if (vs_prev) begin
                    check_val("vsync_start_y", 64'(vga.pixel_y), 64'(V_ACTIVE + V_FP));
                    check_val("vsync_start_x", 64'(vga.pixel_x), 64'd0);
                end
                vs_run++;
            end else if (vs_run > 0) begin
                check_val("vsync_width", 64'(vs_run), 64'(V_SYNC * HT));
                vs_run = 0;
            end
            vs_prev = vga.vsync;
        end
    end

    // Entry timing: locked is high from the current negedge; the first
    // running output appears after the 18th following posedge.
    task automatic check_entry(input string tag);
        repeat (17) @(posedge pixel_clk);
        @(negedge pixel_clk);
        check_val({tag, "_early"}, 64'(vga.running), 64'd0);
        @(posedge pixel_clk);
        @(negedge pixel_clk);
        check_val({tag, "_run"}, 64'(vga.running), 64'd1);
        check_val({tag, "_fs"}, 64'(vga.frame_start), 64'd1);
        check_val({tag, "_xy"}, 64'({vga.pixel_x, vga.pixel_y}), 64'd0);
        check_val({tag, "_de"}, 64'(vga.de), 64'd1);
    endtask

    initial begin
        int n;
        reset  = 1'b1;
        locked = 1'b0;
        repeat (3) @(negedge pixel_clk);
        check_val("reset_idle", observed(), pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0));
        reset = 1'b0;
        repeat (4) @(negedge pixel_clk);

        // First lock and two free-running frames
        locked = 1'b1;
        check_entry("entry1");
        repeat (2 * HT * VT + 10) @(negedge pixel_clk);

        // Lock loss mid-frame
        n = 0;
        while (!(vga.pixel_y == Y_W'(5) && vga.pixel_x == X_W'(3)) && n < 1000) begin
            @(negedge pixel_clk);
            n++;
        end
        check_val("wait_y5", 64'(n < 1000), 64'd1);
        locked = 1'b0;
        repeat (2) @(negedge pixel_clk);
        check_val("drop_idle", observed(), pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0));
        repeat (2) @(negedge pixel_clk);
        locked = 1'b1;
        check_entry("relock");
        repeat (40) @(negedge pixel_clk);

        // One-cycle lock glitch at settle count 10
        locked = 1'b0;
        repeat (3) @(negedge pixel_clk);
        locked = 1'b1;
        repeat (11) @(posedge pixel_clk);
        @(negedge pixel_clk);
        locked = 1'b0;
        @(negedge pixel_clk);
        locked = 1'b1;
        check_entry("glitch");
        repeat (30) @(negedge pixel_clk);

        // Single-cycle reset while running and locked
        reset = 1'b1;
        @(negedge pixel_clk);
        reset = 1'b0;
        check_val("rst_idle", observed(), pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0));
        check_entry("rst_restart");
        repeat (60) @(negedge pixel_clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Consumes the MMCM pixel clock and its lock indicator.
- Produces VGA raster timing: hsync, vsync, data-enable, pixel coordinates, and frame/line strobes.
- Sits between the pixel clock generator and the pixel/colour pipeline that drives the VGA DAC pins.
- Holds the raster idle until the clock has been locked and stable for a programmable settle time.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- HSYNC_POL, 1'b0, active level of hsync (0 = active-low)
- VSYNC_POL, 1'b0, active level of vsync
- SETTLE_CYCLES, 1024, consecutive locked cycles required before the raster starts (≥1)

Ports:
- pixel_clk  in  1  pixel clock; sole clock domain
- reset  in  1  synchronous, active-high reset
- locked  in  1  MMCM lock; treated as synchronous to pixel_clk
- hsync  out  1  horizontal sync, polarity per HSYNC_POL
- vsync  out  1  vertical sync, polarity per VSYNC_POL
- de  out  1  high during active video
- pixel_x  out  X_W  column, X_W = $clog2(H_TOTAL)
- pixel_y  out  Y_W  line, Y_W = $clog2(V_TOTAL)
- line_start  out  1  one-cycle pulse at h=0
- frame_start  out  1  one-cycle pulse at h=0, v=0
- running  out  1  high while FSM is in RUN

Behaviour:
- Derived constants: H_TOTAL = sum of H_* (800); V_TOTAL = sum of V_* (525).
- FSM states: WAIT_LOCK, SETTLE, RUN.
  - WAIT_LOCK: locked=1 -> SETTLE, with settle_cnt cleared.
  - SETTLE: settle_cnt increments each cycle; locked=0 -> WAIT_LOCK; settle_cnt == SETTLE_CYCLES-1 with locked=1 -> RUN.
  - RUN: locked=0 -> WAIT_LOCK.
- Entry into RUN: h_cnt and v_cnt are 0 in the first RUN cycle (T0).
- Counters while in RUN:
  - h_cnt wraps H_TOTAL-1 -> 0.
  - v_cnt increments only on the h wrap, and wraps V_TOTAL-1 -> 0.
- Counters outside RUN: held at 0.
- Output decode (from h_cnt/v_cnt, all outputs registered):
  - de = (h < H_ACTIVE) && (v < V_ACTIVE)
  - hsync active when H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC
  - vsync active when V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC
  - pixel_x = h, pixel_y = v
- Latency: every output is registered with 1 cycle of latency from the counters, so the output for count k appears at T0+k+1. All outputs are mutually aligned.
- Idle output values (reset, and every cycle not in RUN): hsync=~HSYNC_POL, vsync=~VSYNC_POL, de=0, pixel_x=0, pixel_y=0, line_start=0, frame_start=0, running=0.
- Reset: reset=1 forces WAIT_LOCK and idle outputs on the next edge, regardless of locked. reset takes priority over all transitions.
- Lock loss mid-frame: the FSM goes to WAIT_LOCK on the next edge and outputs go idle one cycle later. No partial-frame completion. The next RUN entry restarts at h=0, v=0 with a frame_start pulse.
- Lock glitch during SETTLE: settle restarts from zero (full SETTLE_CYCLES required again).
- Invariants:
  - Exactly one frame_start per V_TOTAL*H_TOTAL cycles in RUN.
  - line_start also pulses on a frame_start cycle.

Decomposition:
- vga_timing_pkg holds:
  - typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN} vga_lock_state_t
  - default 640x480@60 timing constants
  - H_TOTAL/V_TOTAL helper functions
- One sub-module: vga_lock_qualifier, containing the FSM and settle counter, with outputs run_en and run_start.
- The raster counters and decode stay in vga_timing_gen.

Test Plan:
- SETTLE_CYCLES=16, locked raised and sampled at cycle L -> RUN at L+17; frame_start=1 at T0+1 with pixel_x=0, pixel_y=0, de=1.
- Free-run one line -> hsync=0 for cycles T0+657..T0+752 (96 cycles); de high T0+1..T0+640; line_start pulses at T0+801 with pixel_y=1.
- Free-run two frames -> vsync=0 for exactly 2 lines (1600 cycles) starting at pixel_y=490; frame_start period 420000 cycles; pixel_y never exceeds 524 and pixel_x never exceeds 799.
- Drop locked at pixel_y=200 -> running=0 and hsync/vsync=1, de=0 within 2 cycles; relock -> after 16 settle cycles, frame_start with pixel_x=0, pixel_y=0.
- Pulse locked low for 1 cycle at settle count 10 -> RUN entered 16 cycles after locked returns high, not earlier.
- Assert reset for 1 cycle during RUN with locked=1 -> idle outputs next cycle; raster restarts after 1+16 cycles.
